dct_butterfly_sequencer: RTL

Time-multiplexes one registered radix-2 DCT butterfly datapath (18-bit samples, one pair per cycle) across all log2(N) stages of an N-point transform.
- Accepts a block of N samples serially over a valid/ready port and stores it in a ping-pong register buffer.
- Issues butterfly pairs stage by stage in constant-geometry order and captures results back into the buffer.
- Streams the transformed block out over a valid/ready port.
- Sits between the sample front-end and the butterfly wrapper. The wrapper selects the per-stage coefficient instance using bb_stage.

---
 rtl/dct_pkg.sv | 21 ++
 rtl/dct_butterfly_sequencer_if.sv | 37 +++
 rtl/dct_lat_pipe.sv | 34 +++
 rtl/dct_butterfly_sequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants, types and helpers for the DCT butterfly sequencer.
package dct_pkg;

  localparam int SAMPLE_W = 18;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_UNLOAD = 2'd3;

  // Ceiling log2; equals log2 for the power-of-two sizes used here.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/dct_butterfly_sequencer_if.sv
// Sample, result and butterfly-operand buses of the DCT butterfly sequencer.
interface dct_butterfly_sequencer_if
  import dct_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = SAMPLE_W
);

  localparam int SGW = clog2(N);

  // in_* and out_* use valid/ready: a word moves on a rising clk edge where
  // valid and ready are both high; the sender holds the word stable while
  // valid is high and ready is low. bb_* has no backpressure.
  logic           in_valid;
  logic           in_ready;
  logic [SW-1:0]  in_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_data;
  logic           bb_valid;
  logic [SW-1:0]  bb_top;
  logic [SW-1:0]  bb_bot;
  logic [SGW-1:0] bb_stage;
  logic [SW-1:0]  bb_top_res;
  logic [SW-1:0]  bb_bot_res;

  modport master (
    input  in_valid, in_data, out_ready, bb_top_res, bb_bot_res,
    output in_ready, out_valid, out_data, bb_valid, bb_top, bb_bot, bb_stage
  );

  modport slave (
    output in_valid, in_data, out_ready, bb_top_res, bb_bot_res,
    input  in_ready, out_valid, out_data, bb_valid, bb_top, bb_bot, bb_stage
  );

endinterface

// File: rtl/dct_lat_pipe.sv
// Delay line carrying {valid, pair index} alongside the external butterfly.
module dct_lat_pipe #(
  parameter int LAT = 1,
  parameter int IW  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  input  logic [IW-1:0] i_idx,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  logic [LAT-1:0] r_valid;
  logic [IW-1:0]  r_idx [LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < LAT; i++) r_idx[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_idx[0]   <= i_idx;
      for (int i = 1; i < LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_idx[i]   <= r_idx[i-1];
      end
    end
  end

  assign o_valid = r_valid[LAT-1];
  assign o_idx   = r_idx[LAT-1];

endmodule

// File: rtl/dct_butterfly_sequencer.sv
// Runs all log2(N) stages of an N-point DCT through one shared butterfly,
// holding the block in a ping-pong register buffer between stages.
module dct_butterfly_sequencer
  import dct_pkg::*;
#(
  parameter int N      = 8,
  parameter int SW     = SAMPLE_W,
  parameter int BB_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  dct_butterfly_sequencer_if.master  io_bus,
  output logic                       busy,
  output logic [1:0]                 o_dbg_state
);

  localparam int S    = clog2(N);
  localparam int IW   = clog2(N);
  localparam int SGW  = clog2(N);
  localparam int PW   = IW - 1;
  localparam int HALF = N / 2;
  localparam int DW   = (BB_LAT > 1) ? clog2(BB_LAT) : 1;

  logic [1:0]     r_state;
  logic [IW-1:0]  r_ld_cnt;
  logic [IW-1:0]  r_ul_cnt;
  logic [IW-1:0]  r_p;
  logic [SGW-1:0] r_s;
  logic [DW-1:0]  r_dr_cnt;
  logic           r_bank;
  logic [SW-1:0]  r_buf [2][N];

  logic           w_load;
  logic           w_issue;
  logic           w_unload;
  logic           w_ld_fire;
  logic [IW-1:0]  w_bot_idx;
  logic           w_cap_valid;
  logic [PW-1:0]  w_cap_idx;
  logic [IW-1:0]  w_cap_even;
  logic [IW-1:0]  w_cap_odd;

  assign w_load    = (r_state == ST_LOAD);
  assign w_issue   = (r_state == ST_ISSUE);
  assign w_unload  = (r_state == ST_UNLOAD);
  assign w_ld_fire = io_bus.in_valid && w_load;
  assign w_bot_idx = r_p + IW'(HALF);

  dct_lat_pipe #(
    .LAT (BB_LAT),
    .IW  (PW)
  ) u_lat_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_issue),
    .i_idx   (r_p[PW-1:0]),
    .o_valid (w_cap_valid),
    .o_idx   (w_cap_idx)
  );

  // Results land in perfect-shuffle order: pair p -> slots 2p and 2p+1.
  assign w_cap_even = {w_cap_idx, 1'b0};
  assign w_cap_odd  = {w_cap_idx, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_LOAD;
      r_ld_cnt <= '0;
      r_ul_cnt <= '0;
      r_p      <= '0;
      r_s      <= '0;
      r_dr_cnt <= '0;
      r_bank   <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_ld_fire) begin
            if (r_ld_cnt == IW'(N-1)) begin
              r_ld_cnt <= '0;
              r_s      <= '0;
              r_p      <= '0;
              r_state  <= ST_ISSUE;
            end else begin
              r_ld_cnt <= r_ld_cnt + IW'(1);
            end
          end
        end
        ST_ISSUE: begin
          r_p <= r_p + IW'(1);
          if (r_p == IW'(HALF-1)) begin
            r_dr_cnt <= '0;
            r_state  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The last capture of the stage lands on this same edge, so the
          // bank swap never races the write into the outgoing nxt bank.
          if (r_dr_cnt == DW'(BB_LAT-1)) begin
            r_bank <= ~r_bank;
            r_p    <= '0;
            if (r_s == SGW'(S-1)) begin
              r_state <= ST_UNLOAD;
            end else begin
              r_s     <= r_s + SGW'(1);
              r_state <= ST_ISSUE;
            end
          end else begin
            r_dr_cnt <= r_dr_cnt + DW'(1);
          end
        end
        ST_UNLOAD: begin
          if (io_bus.out_ready) begin
            if (r_ul_cnt == IW'(N-1)) begin
              r_ul_cnt <= '0;
              r_bank   <= 1'b0;
              r_state  <= ST_LOAD;
            end else begin
              r_ul_cnt <= r_ul_cnt + IW'(1);
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (w_ld_fire) begin
      r_buf[r_bank][r_ld_cnt] <= io_bus.in_data;
    end
    if (w_cap_valid) begin
      r_buf[~r_bank][w_cap_even] <= io_bus.bb_top_res;
      r_buf[~r_bank][w_cap_odd]  <= io_bus.bb_bot_res;
    end
  end

  assign io_bus.in_ready  = w_load && !reset;
  assign io_bus.out_valid = w_unload;
  assign io_bus.out_data  = w_unload ? r_buf[r_bank][r_ul_cnt] : '0;
  assign io_bus.bb_valid  = w_issue;
  assign io_bus.bb_top    = w_issue ? r_buf[r_bank][r_p] : '0;
  assign io_bus.bb_bot    = w_issue ? r_buf[r_bank][w_bot_idx] : '0;
  assign io_bus.bb_stage  = w_issue ? r_s : '0;

  assign busy        = !w_load;
  assign o_dbg_state = r_state;

endmodule
